// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: configuration-chain controller for the routing tiles' mux-memory scan chain.
// It serialises bitstream words MSB-first into ccff_head while gating the chain with ccff_shift_en.
// It can also recirculate the chain once and compare a CRC-8 of the tail bits against the loaded bits.
// Ports:
//   prog_clk, pReset             : programming clock, asynchronous active-high reset
//   start, check_en              : start pulse, and whether to run the CHECK phase after LOAD
//   word_data/valid/ready        : bitstream word intake (valid/ready handshake)
//   ccff_head, ccff_shift_en     : serial data and shift enable toward the chain head
//   ccff_tail                    : serial data returning from the chain tail
//   busy, done, error, err_code  : status (err_code 01 = CRC mismatch, 10 = dirty tail on first load)
module ccff_chain_loader #(
   parameter int unsigned CHAIN_LEN = 58,
   parameter int unsigned WORD_W    = 8,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic              check_en,
   input  logic [WORD_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_code
);

   localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int unsigned CRC_W = 8;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
   localparam logic [IDX_W-1:0] REM_FULL = IDX_W'(WORD_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CHECK,
      S_DONE,
      S_ERR
   } state_e;

   state_e             state_q, state_d;
   logic [WORD_W-1:0]  sh_q, sh_d;          // bits still to present, MSB next
   logic [IDX_W-1:0]   rem_q, rem_d;        // bits left in sh_q after the presented one
   logic               hv_q, hv_d;          // shifter is presenting a bit
   logic               head_q, head_d;      // presented bit; holds when the shifter is empty
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CRC_W-1:0]   crc_load_q, crc_load_d;
   logic [CRC_W-1:0]   crc_tail_q, crc_tail_d;
   logic               chk_en_q, chk_en_d;
   logic               first_q, first_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               error_q, error_d;
   logic [1:0]         err_code_q, err_code_d;
   logic               accept;

   // Bit-serial CRC-8, polynomial 0x07
   function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc, input logic b);
      logic fb;
      fb = crc[CRC_W-1] ^ b;
      return {crc[CRC_W-2:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
   endfunction

   // A new word may land while the shifter is empty, or on its last bit unless that bit completes the chain
   assign word_ready    = (state_q == S_LOAD) &&
                          (!hv_q || ((rem_q == '0) && (cnt_q != LAST_BIT)));
   assign accept        = word_ready && word_valid;
   assign ccff_shift_en = ((state_q == S_LOAD) && hv_q) || (state_q == S_CHECK);
   // During CHECK the tail is fed straight back to the head so the chain content is preserved
   assign ccff_head     = (state_q == S_CHECK) ? ccff_tail : head_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;
   assign err_code      = err_code_q;

   // State register
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         state_q    <= S_IDLE;
         sh_q       <= '0;
         rem_q      <= '0;
         hv_q       <= 1'b0;
         head_q     <= 1'b0;
         cnt_q      <= '0;
         crc_load_q <= '0;
         crc_tail_q <= '0;
         chk_en_q   <= 1'b0;
         first_q    <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         err_code_q <= '0;
      end else begin
         state_q    <= state_d;
         sh_q       <= sh_d;
         rem_q      <= rem_d;
         hv_q       <= hv_d;
         head_q     <= head_d;
         cnt_q      <= cnt_d;
         crc_load_q <= crc_load_d;
         crc_tail_q <= crc_tail_d;
         chk_en_q   <= chk_en_d;
         first_q    <= first_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         err_code_q <= err_code_d;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d    = state_q;
      sh_d       = sh_q;
      rem_d      = rem_q;
      hv_d       = hv_q;
      head_d     = head_q;
      cnt_d      = cnt_q;
      crc_load_d = crc_load_q;
      crc_tail_d = crc_tail_q;
      chk_en_d   = chk_en_q;
      first_d    = first_q;
      busy_d     = busy_q;
      done_d     = done_q;
      error_d    = error_q;
      err_code_d = err_code_q;

      unique case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d    = S_LOAD;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               error_d    = 1'b0;
               err_code_d = 2'b00;
               crc_load_d = '0;
               crc_tail_d = '0;
               cnt_d      = '0;
               hv_d       = 1'b0;
               chk_en_d   = check_en;
            end
         end

         S_LOAD: begin
            if (hv_q) begin
               cnt_d      = cnt_q + CNT_W'(1);
               crc_load_d = crc8_step(crc_load_q, head_q);
               if (first_q && ccff_tail) begin
                  // A freshly reset chain must emit zeros; a one means a broken or stuck chain
                  state_d    = S_ERR;
                  busy_d     = 1'b0;
                  error_d    = 1'b1;
                  err_code_d = 2'b10;
                  hv_d       = 1'b0;
                  first_d    = 1'b0;
               end else if (cnt_q == LAST_BIT) begin
                  // Chain full: any remaining low-order bits of this word are dropped
                  hv_d    = 1'b0;
                  first_d = 1'b0;
                  if (chk_en_q) begin
                     state_d = S_CHECK;
                     cnt_d   = '0;
                  end else begin
                     state_d = S_DONE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end
               end else if (rem_q != '0) begin
                  head_d = sh_q[WORD_W-1];
                  sh_d   = sh_q << 1;
                  rem_d  = rem_q - IDX_W'(1);
               end else begin
                  hv_d = 1'b0;
               end
            end
            if (accept && (state_d == S_LOAD)) begin
               head_d = word_data[WORD_W-1];
               sh_d   = word_data << 1;
               rem_d  = REM_FULL;
               hv_d   = 1'b1;
            end
         end

         S_CHECK: begin
            crc_tail_d = crc8_step(crc_tail_q, ccff_tail);
            cnt_d      = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               busy_d = 1'b0;
               if (crc_tail_d == crc_load_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d    = S_ERR;
                  error_d    = 1'b1;
                  err_code_d = 2'b01;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

endmodule
